// File: rtl/commutation_control.sv
// Six-step BLDC commutation: Hall sensors + user command -> registered gate enables.
// Optional dead interval between differing non-zero patterns: define COMMUTATION_DEADTIME_EN.
module commutation_control #(
  parameter int DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] UI,
  input  logic [2:0] HS,
  output logic [5:0] PT
);

  logic [5:0] w_ccw;
  logic [5:0] w_cw;
  logic [5:0] w_brk2;
  logic [5:0] w_dec;
  logic [5:0] r_pt;

  // Per-Hall-state patterns for every position-dependent mode; invalid HS leaves all zero.
  always_comb begin
    w_ccw  = 6'b000000;
    w_cw   = 6'b000000;
    w_brk2 = 6'b000000;
    case (HS)
      3'b100: begin w_ccw = 6'b100100; w_cw = 6'b011000; w_brk2 = 6'b010100; end
      3'b110: begin w_ccw = 6'b100001; w_cw = 6'b010010; w_brk2 = 6'b010001; end
      3'b010: begin w_ccw = 6'b001001; w_cw = 6'b000110; w_brk2 = 6'b000101; end
      3'b011: begin w_ccw = 6'b011000; w_cw = 6'b100100; w_brk2 = 6'b010100; end
      3'b001: begin w_ccw = 6'b010010; w_cw = 6'b100001; w_brk2 = 6'b010001; end
      3'b101: begin w_ccw = 6'b000110; w_cw = 6'b001001; w_brk2 = 6'b000101; end
      default: ;
    endcase
  end

  always_comb begin
    w_dec = 6'b000000;
    case (UI)
      3'b010:  w_dec = w_ccw;
      3'b100:  w_dec = w_cw;
      3'b001:  w_dec = 6'b010101;
      3'b110:  w_dec = w_brk2;
      default: w_dec = 6'b000000;
    endcase
  end

`ifdef COMMUTATION_DEADTIME_EN
  logic [3:0] r_cnt;
  logic [5:0] r_target;

  // r_cnt != 0 means a dead interval is running with gates off; r_target is what follows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pt     <= 6'b000000;
      r_target <= 6'b000000;
      r_cnt    <= 4'd0;
    end else if (w_dec == 6'b000000) begin
      r_pt     <= 6'b000000;
      r_target <= 6'b000000;
      r_cnt    <= 4'd0;
    end else if (r_cnt != 4'd0) begin
      r_pt <= 6'b000000;
      if (w_dec != r_target) begin
        r_target <= w_dec;
        r_cnt    <= 4'(DEAD_CYCLES);
      end else if (r_cnt == 4'd1) begin
        r_pt  <= r_target;
        r_cnt <= 4'd0;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end else if (r_pt == 6'b000000) begin
      r_pt <= w_dec;
    end else if (w_dec != r_pt) begin
      r_pt     <= 6'b000000;
      r_target <= w_dec;
      r_cnt    <= 4'(DEAD_CYCLES);
    end
  end
`else
  logic [3:0] w_unused_dead;
  assign w_unused_dead = 4'(DEAD_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pt <= 6'b000000;
    else     r_pt <= w_dec;
  end
`endif

  assign PT = r_pt;

endmodule

// File: tb/tb_commutation_control.sv
// Scoreboard bench for commutation_control: expectations queued at drive time, checked after each edge.
module tb_commutation_control;

  localparam int DEAD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] UI;
  logic [2:0] HS;
  logic [5:0] PT;

  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  commutation_control #(.DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst(rst), .UI(UI), .HS(HS), .PT(PT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  // Reference decode written straight from the Hall-state tables.
  function automatic logic [5:0] model(input logic [2:0] ui, input logic [2:0] hs);
    int st;
    logic [5:0] r;
    case (hs)
      3'b100: st = 1;
      3'b110: st = 2;
      3'b010: st = 3;
      3'b011: st = 4;
      3'b001: st = 5;
      3'b101: st = 6;
      default: st = 0;
    endcase
    r = 6'b000000;
    if (ui == 3'b001) r = 6'b010101;
    else if (ui == 3'b010) begin
      case (st)
        1: r = 6'b100100; 2: r = 6'b100001; 3: r = 6'b001001;
        4: r = 6'b011000; 5: r = 6'b010010; 6: r = 6'b000110;
        default: r = 6'b000000;
      endcase
    end else if (ui == 3'b100) begin
      case (st)
        1: r = 6'b011000; 2: r = 6'b010010; 3: r = 6'b000110;
        4: r = 6'b100100; 5: r = 6'b100001; 6: r = 6'b001001;
        default: r = 6'b000000;
      endcase
    end else if (ui == 3'b110) begin
      case (st)
        1, 4: r = 6'b010100;
        2, 5: r = 6'b010001;
        3, 6: r = 6'b000101;
        default: r = 6'b000000;
      endcase
    end
    return r;
  endfunction

  task automatic drive(input logic [2:0] ui, input logic [2:0] hs, input logic [5:0] exp, input string tag);
    @(negedge clk);
    UI = ui;
    HS = hs;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic drive_m(input logic [2:0] ui, input logic [2:0] hs, input string tag);
    drive(ui, hs, model(ui, hs), tag);
  endtask

  // Monitor: shoot-through every cycle, scoreboard pop when an expectation is due.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("shoot", {3'b000, PT[5] & PT[4], PT[3] & PT[2], PT[1] & PT[0]}, 6'b000000);
      if (exp_q.size() > 0) check(tag_q.pop_front(), PT, exp_q.pop_front());
    end
  end

  logic [2:0] halls[6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  logic [2:0] ccw_seq[7] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  logic [5:0] ccw_exp[7] = '{6'b000110, 6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
  logic [2:0] rev_seq[6] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
  logic [5:0] cw_exp[6]  = '{6'b001001, 6'b100001, 6'b100100, 6'b000110, 6'b010010, 6'b011000};
  logic [5:0] br2_exp[6] = '{6'b000101, 6'b010001, 6'b010100, 6'b000101, 6'b010001, 6'b010100};

  initial begin
    rst = 1'b1;
    UI  = 3'b010;
    HS  = 3'b100;
    #2;
    check("rst_async", PT, 6'b000000);
    repeat (2) @(posedge clk);
    #1 check("rst_held", PT, 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release_no_edge", PT, 6'b000000);
    drive(3'b010, 3'b100, 6'b100100, "rst_first");

`ifdef COMMUTATION_DEADTIME_EN
    drive(3'b010, 3'b110, 6'b000000, "dead_start");
    for (int i = 1; i < DEAD; i++) drive(3'b010, 3'b110, 6'b000000, "dead_hold");
    drive(3'b010, 3'b110, 6'b100001, "dead_end");
`else
    for (int i = 0; i < 6; i++) drive(3'b000, halls[i], 6'b000000, "off");
    for (int i = 0; i < 7; i++) drive(3'b010, ccw_seq[i], ccw_exp[i], "ccw");
    for (int i = 0; i < 6; i++) drive(3'b100, rev_seq[i], cw_exp[i], "cw");
    for (int i = 0; i < 6; i++) drive(3'b110, rev_seq[i], br2_exp[i], "brake2");
    for (int i = 0; i < 8; i++) drive(3'b001, 3'(i), 6'b010101, "brake1");
    for (int i = 0; i < 6; i++) drive(3'b111, halls[i], 6'b000000, "conflict111");
    for (int i = 0; i < 6; i++) drive(3'b101, halls[i], 6'b000000, "conflict101");
    drive(3'b011, 3'b010, 6'b000000, "conflict011");
    drive(3'b010, 3'b000, 6'b000000, "ccw_hs000");
    drive(3'b010, 3'b111, 6'b000000, "ccw_hs111");
    drive(3'b110, 3'b000, 6'b000000, "brake2_hs000");
    for (int i = 0; i < 60; i++) begin
      logic [2:0] ui_r;
      logic [2:0] hs_r;
      ui_r = 3'($urandom_range(0, 7));
      hs_r = 3'($urandom_range(0, 7));
      drive_m(ui_r, hs_r, "random");
    end
    drive(3'b010, 3'b011, 6'b011000, "pre_reset");
`endif

    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_async", PT, 6'b000000);
    @(posedge clk);
    #1 check("rst_mid_held", PT, 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b100, 3'b100, 6'b011000, "after_reset");

    repeat (3) @(posedge clk);
    #2 check("drain", 6'(exp_q.size()), 6'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
